imem_ctrl: RTL
==============

# imem_ctrl

Sequencing controller for the 32-word instruction memory. It owns the memory's `add`/`data`/`write` ports and drives its `pc` port. After reset or a `start` pulse it loads a program from a byte stream into consecutive words, holding the fetch path stalled. In run mode it passes the fetch PC through and gives debug write requests priority over fetch.

## Interface
- `DEPTH`, 32: number of memory words; addresses `0..DEPTH-1`
- `AW`, 5: word address width, equal to clog2(DEPTH)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse that begins a load; honoured only in `IDLE`
- `len`  in  AW+1  number of words to load, sampled on `start`; values above DEPTH clamp to DEPTH
- `byte_valid`  in  1  loader byte valid
- `byte_data`  in  8  loader byte, little-endian within a word
- `byte_ready`  out  1  controller accepts a byte
- `fetch_pc`  in  32  CPU fetch address
- `fetch_stall`  out  1  CPU must hold its PC
- `dbg_wr_req`  in  1  debug write request, level
- `dbg_add`  in  32  debug write word address
- `dbg_data`  in  32  debug write data
- `dbg_wr_ack`  out  1  one-cycle completion pulse
- `mem_pc`  out  32  to the memory `pc` port
- `mem_add`  out  32  to the memory `add` port
- `mem_data`  out  32  to the memory `data` port
- `mem_write`  out  1  to the memory `write` port
- `busy`  out  1  high in any state other than `IDLE`
- `done`  out  1  one-cycle pulse at the end of a load
- `load_err`  out  1  checksum mismatch, sticky (see Configuration)

## Operation
- **States:** `IDLE`, `LOAD`, `SETUP`, `STROBE`, `DSETUP`, `DSTROBE`, plus `CHECK` when the Configuration macro is defined.
- **IDLE:**
  - `start` → `LOAD`, clearing the word counter and byte counter.
  - `start` with a clamped `len` of 0 → stays in `IDLE` and pulses `done` on the next cycle.
  - Otherwise, `dbg_wr_req` → `DSETUP`.
  - If `start` and `dbg_wr_req` are both high, `start` wins.
- **LOAD:**
  - `byte_ready`=1. Each `byte_valid & byte_ready` shifts `byte_data` into byte lane `bcnt`, which then increments.
  - On the 4th byte → `SETUP`.
- **SETUP:** `mem_add`=`wcnt`, `mem_data`=assembled word, `mem_write`=0 → `STROBE`.
- **STROBE:**
  - `mem_write`=1, address and data held, `wcnt` increments.
  - If `wcnt+1==len` → `IDLE` with `done` (or → `CHECK` when the macro is defined). Otherwise → `LOAD`.
- **DSETUP:**
  - `mem_add`=`dbg_add`, `mem_data`=`dbg_data`, `mem_write`=0 → `DSTROBE`.
- **DSTROBE:**
  - `mem_write`=1 only if `dbg_add < DEPTH`; an out-of-range write is dropped silently.
  - `dbg_wr_ack`=1 → `IDLE`. `dbg_wr_req` must fall after the ack; a still-high request is treated as a new write.
- **fetch_stall and mem_pc:**
  - `fetch_stall`=1 in every state other than `IDLE`.
  - In `IDLE`, `mem_pc` follows `fetch_pc` combinationally.
  - Otherwise `mem_pc` holds the value registered on the last `IDLE` cycle.
- **Address rule:** `mem_add` is zero-extended from the `AW`-bit counter during loads.

## Timing
- **Reset values:**
  - state `IDLE`; `wcnt`, `bcnt` and the assembly register 0
  - `mem_write`, `byte_ready`, `dbg_wr_ack`, `done`, `busy`, `load_err` all 0
  - `mem_add`, `mem_data` and registered `mem_pc` all 0
  - `fetch_stall`=0
- **mem_write:** registered. It is high for exactly one cycle, with `mem_add`/`mem_data` stable one cycle before, during, and one cycle after the pulse. This gives the memory's level-triggered write a setup window.
- **Word cost:** 4 byte cycles (at best) plus `SETUP` plus `STROBE`, so 6 cycles per word minimum. An N-word load raises `done` at cycle 6N+1 after `start`.
- **Debug write:** ack 2 cycles after the `IDLE` cycle that samples the request; fetch is stalled for those 2 cycles.
- **Back-pressure:** bytes presented outside `LOAD` are not accepted and are not lost; the source holds them.
- **Reset mid-operation:** returns to `IDLE` within the reset assertion. Partial words are discarded and `mem_write` drops immediately with no partial strobe.
- **Restart:** `start` during a load is ignored.

## Configuration
- **`IMEM_CHECKSUM_EN` defined:**
  - A 32-bit running sum (mod 2^32) of the written words is kept.
  - After the last `STROBE`, the FSM enters `CHECK` and accepts 4 more trailer bytes.
  - `load_err`=1 if the trailer differs from the sum; `done` pulses either way.
  - `load_err` clears on the next accepted `start`.
- **`IMEM_CHECKSUM_EN` undefined:** no trailer is expected, the `CHECK` state and sum register are absent, and `load_err` is tied 0.

## Structure
- **Package `imem_ctrl_pkg`:**
  - state enum
  - `DEPTH`/`AW` defaults
  - `BYTES_PER_WORD`=4
- **Sub-module `byte_packer`:** 8-bit to 32-bit little-endian assembler with lane counter and `word_valid`, cleared by `rst_n` or `start`.

## Test plan
- **Reset:** release `rst_n` → all outputs 0 and `fetch_stall`=0; `fetch_pc`=0x4 → `mem_pc`=0x4 the same cycle.
- **Two-word load:** `start` with `len`=2, then bytes 78 56 34 12 EF BE AD DE back-to-back → `mem_write` pulses with (0, 0x12345678) then (1, 0xDEADBEEF); `done` at cycle 13; `fetch_stall` high throughout.
- **Debug write:** `dbg_add`=3, `dbg_data`=0xCAFEF00D → one strobe, ack 2 cycles later, `fetch_stall` high for exactly 2 cycles, `mem_pc` frozen during the stall.
- **Out-of-range debug write:** `dbg_add`=40 → `dbg_wr_ack` pulses with no `mem_write` pulse.
- **Reset mid-load:** assert `rst_n`=0 after 2 bytes of word 0 → no `mem_write` pulse; a subsequent load writes at address 0.
- **Checksum (`IMEM_CHECKSUM_EN` defined):** `len`=1, word 0x00000001, trailer 0x00000002 → `load_err`=1 and `done` pulses; reload with trailer 0x00000001 → `load_err`=0.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg: shared constants and FSM state type for the instruction
// memory sequencing controller.
// Optional feature macro: IMEM_CHECKSUM_EN adds the CHECK state.
package imem_ctrl_pkg;

   localparam int unsigned DEPTH          = 32;
   localparam int unsigned AW             = 5;
   localparam int unsigned BYTES_PER_WORD = 4;

`ifdef IMEM_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_SETUP, ST_STROBE, ST_DSETUP, ST_DSTROBE, ST_CHECK
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_SETUP, ST_STROBE, ST_DSETUP, ST_DSTROBE
   } state_t;
`endif

endpackage

// File: rtl/imem_ctrl_byte_packer.sv
// byte_packer: assembles a little-endian 32-bit word from a byte stream.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   i_clear          synchronous clear of lane counter and word (load start)
//   i_push           a byte is accepted this cycle
//   i_byte           byte value
//   o_word_c         word including this cycle's byte (combinational)
//   o_word_valid_c   this push completes a word (combinational)
module byte_packer
   import imem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clear,
   input  logic        i_push,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word_c,
   output logic        o_word_valid_c
);

   localparam int unsigned LW = $clog2(BYTES_PER_WORD);

   logic [LW-1:0] r_bcnt;
   logic [31:0]   r_word;
   logic [31:0]   w_word_nxt;

   // Merge the incoming byte into its lane so the completed word is usable
   // in the same cycle as the last byte.
   always_comb begin
      w_word_nxt = r_word;
      if (i_push) w_word_nxt[{r_bcnt, 3'b000} +: 8] = i_byte;
   end

   assign o_word_c       = w_word_nxt;
   assign o_word_valid_c = i_push && (r_bcnt == LW'(BYTES_PER_WORD - 1));

   // Lane counter wraps naturally after the last lane.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcnt <= '0;
         r_word <= '0;
      end else if (i_clear) begin
         r_bcnt <= '0;
         r_word <= '0;
      end else if (i_push) begin
         r_bcnt <= r_bcnt + LW'(1);
         r_word <= w_word_nxt;
      end
   end

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: sequencing controller for the 32-word instruction memory.
// Loads a program from a byte stream after start, services debug writes,
// and passes the fetch PC through while idle.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_start, i_len             load request and word count (clamped to DEPTH)
//   i_byte_valid/data, o_byte_ready   loader byte stream
//   i_fetch_pc, o_fetch_stall  CPU fetch side
//   i_dbg_wr_req/add/data, o_dbg_wr_ack   debug write port
//   o_mem_pc/add/data/write    memory ports (o_mem_pc is combinational in IDLE)
//   o_busy, o_done, o_load_err status
// Optional feature macro: IMEM_CHECKSUM_EN (trailer checksum after a load).
module imem_ctrl
   import imem_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic [AW:0]   i_len,
   input  logic          i_byte_valid,
   input  logic [7:0]    i_byte_data,
   output logic          o_byte_ready,
   input  logic [31:0]   i_fetch_pc,
   output logic          o_fetch_stall,
   input  logic          i_dbg_wr_req,
   input  logic [31:0]   i_dbg_add,
   input  logic [31:0]   i_dbg_data,
   output logic          o_dbg_wr_ack,
   output logic [31:0]   o_mem_pc,
   output logic [31:0]   o_mem_add,
   output logic [31:0]   o_mem_data,
   output logic          o_mem_write,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_load_err
);

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_wcnt, w_wcnt_nxt;
   logic [AW:0]   r_len, w_len_nxt, w_len_clamp, w_wcnt_inc;
   logic [31:0]   r_mem_add, w_mem_add_nxt;
   logic [31:0]   r_mem_data, w_mem_data_nxt;
   logic          r_mem_write, w_mem_write_nxt;
   logic          r_byte_ready, w_byte_ready_nxt;
   logic          r_ack, w_ack_nxt;
   logic          r_done, w_done_nxt;
   logic          r_busy;
   logic [31:0]   r_pc;
   logic          w_start_ok;
   logic          w_push;
   logic [31:0]   w_word;
   logic          w_word_valid;
`ifdef IMEM_CHECKSUM_EN
   logic [31:0]   r_sum, w_sum_nxt;
   logic          r_load_err, w_err_nxt;
`endif

   assign w_push      = i_byte_valid && r_byte_ready;
   assign w_len_clamp = (i_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : i_len;
   assign w_wcnt_inc  = (AW+1)'(r_wcnt) + (AW+1)'(1);

   byte_packer u_packer (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_clear        (w_start_ok),
      .i_push         (w_push),
      .i_byte         (i_byte_data),
      .o_word_c       (w_word),
      .o_word_valid_c (w_word_valid)
   );

   // Next-state and next-output logic; registered outputs follow the next state.
   always_comb begin
      w_state_nxt      = r_state;
      w_wcnt_nxt       = r_wcnt;
      w_len_nxt        = r_len;
      w_mem_add_nxt    = r_mem_add;
      w_mem_data_nxt   = r_mem_data;
      w_mem_write_nxt  = 1'b0;
      w_ack_nxt        = 1'b0;
      w_done_nxt       = 1'b0;
      w_start_ok       = 1'b0;
      w_byte_ready_nxt = 1'b0;
`ifdef IMEM_CHECKSUM_EN
      w_sum_nxt        = r_sum;
      w_err_nxt        = r_load_err;
`endif
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_start_ok = 1'b1;
               w_wcnt_nxt = '0;
               w_len_nxt  = w_len_clamp;
`ifdef IMEM_CHECKSUM_EN
               w_sum_nxt  = '0;
               w_err_nxt  = 1'b0;
`endif
               if (w_len_clamp == '0) w_done_nxt  = 1'b1;
               else                   w_state_nxt = ST_LOAD;
            end else if (i_dbg_wr_req) begin
               w_state_nxt    = ST_DSETUP;
               w_mem_add_nxt  = i_dbg_add;
               w_mem_data_nxt = i_dbg_data;
            end
         end
         ST_LOAD: begin
            if (w_word_valid) begin
               w_state_nxt    = ST_SETUP;
               w_mem_add_nxt  = 32'(r_wcnt);
               w_mem_data_nxt = w_word;
            end
         end
         ST_SETUP: begin
            w_state_nxt     = ST_STROBE;
            w_mem_write_nxt = 1'b1;
         end
         ST_STROBE: begin
            w_wcnt_nxt = r_wcnt + AW'(1);
`ifdef IMEM_CHECKSUM_EN
            w_sum_nxt  = r_sum + r_mem_data;
`endif
            if (w_wcnt_inc == r_len) begin
`ifdef IMEM_CHECKSUM_EN
               w_state_nxt = ST_CHECK;
`else
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
`endif
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_DSETUP: begin
            // Out-of-range debug writes are acknowledged but never strobed.
            w_state_nxt     = ST_DSTROBE;
            w_mem_write_nxt = (r_mem_add < 32'(DEPTH));
            w_ack_nxt       = 1'b1;
         end
         ST_DSTROBE: begin
            w_state_nxt = ST_IDLE;
         end
`ifdef IMEM_CHECKSUM_EN
         ST_CHECK: begin
            if (w_word_valid) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
               w_err_nxt   = (w_word != r_sum);
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
`ifdef IMEM_CHECKSUM_EN
      w_byte_ready_nxt = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CHECK);
`else
      w_byte_ready_nxt = (w_state_nxt == ST_LOAD);
`endif
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_wcnt       <= '0;
         r_len        <= '0;
         r_mem_add    <= '0;
         r_mem_data   <= '0;
         r_mem_write  <= 1'b0;
         r_byte_ready <= 1'b0;
         r_ack        <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_pc         <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_wcnt       <= w_wcnt_nxt;
         r_len        <= w_len_nxt;
         r_mem_add    <= w_mem_add_nxt;
         r_mem_data   <= w_mem_data_nxt;
         r_mem_write  <= w_mem_write_nxt;
         r_byte_ready <= w_byte_ready_nxt;
         r_ack        <= w_ack_nxt;
         r_done       <= w_done_nxt;
         r_busy       <= (w_state_nxt != ST_IDLE);
         // Remember the last idle PC so the memory sees a frozen PC while stalled.
         if (r_state == ST_IDLE) r_pc <= i_fetch_pc;
      end
   end

`ifdef IMEM_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum      <= '0;
         r_load_err <= 1'b0;
      end else begin
         r_sum      <= w_sum_nxt;
         r_load_err <= w_err_nxt;
      end
   end
   assign o_load_err = r_load_err;
`else
   assign o_load_err = 1'b0;
`endif

   assign o_byte_ready  = r_byte_ready;
   assign o_fetch_stall = r_busy;
   assign o_busy        = r_busy;
   assign o_dbg_wr_ack  = r_ack;
   assign o_done        = r_done;
   assign o_mem_add     = r_mem_add;
   assign o_mem_data    = r_mem_data;
   assign o_mem_write   = r_mem_write;
   assign o_mem_pc      = (r_state == ST_IDLE) ? i_fetch_pc : r_pc;

endmodule
